mem_initiator: RTL and testbench



---
 rtl/mem_initiator.sv | 109 ++++++++++
 tb/tb_mem_initiator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// Bus master for a single-port synchronous memory: turns write, read and burst-read
// commands into memory pin activity and streams captured read words back out.
module mem_initiator #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [AW-1:0] cmd_len,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          busy,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;

    state_t        state;
    logic [AW-1:0] count;
    logic          vld_p1;

    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            vld_p1    <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Stage p1: an address was on the bus while in READ; the memory samples it now
            // and its registered data is captured on the following edge.
            vld_p1    <= (state == READ);
            rsp_valid <= vld_p1;
            if (vld_p1) begin
                rsp_data <= mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                mem_rw    <= 1'b0;
                                mem_addr  <= cmd_addr;
                                mem_wdata <= cmd_wdata;
                                state     <= WRITE;
                            end
                            OP_READ: begin
                                mem_rw   <= 1'b1;
                                mem_addr <= cmd_addr;
                                count    <= '0;
                                state    <= READ;
                            end
                            OP_BURST: begin
                                mem_rw   <= 1'b1;
                                mem_addr <= cmd_addr;
                                count    <= cmd_len;
                                state    <= READ;
                            end
                            // Reserved op: no memory cycle, just complete via DRAIN.
                            default: state <= DRAIN;
                        endcase
                    end
                end
                WRITE: begin
                    mem_rw <= 1'b1;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                READ: begin
                    if (count != '0) begin
                        mem_addr <= mem_addr + 1'b1;
                        count    <= count - 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural 16x4 synchronous memory
// and a shadow copy of its contents for expected read data.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic [3:0] cmd_len;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       done;
    logic       busy;
    logic       mem_rw;
    logic [3:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;

    logic [3:0] mem [16];
    logic [3:0] shadow [16];

    int vectors = 0;
    int miscompares = 0;

    mem_initiator #(.DW(4), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .busy      (busy),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: write when rw=0, otherwise registered read; cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else if (!mem_rw) begin
            mem[mem_addr] <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return in the cycle after its accept edge E0.
    task automatic send(input logic [1:0] op, input logic [3:0] addr,
                        input logic [3:0] wdata, input logic [3:0] len);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_len   = len;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] data);
        send(2'b00, addr, data, 4'd0);
        chk("wr_rw_low", mem_rw, 0);
        chk("wr_addr", mem_addr, addr);
        chk("wr_data", mem_wdata, data);
        tick();
        chk("wr_rw_high", mem_rw, 1);
        chk("wr_done", done, 1);
        shadow[addr] = data;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [3:0] len);
        logic [3:0] a;
        send((len == 0) ? 2'b01 : 2'b10, addr, 4'd0, len);
        chk("rd_addr0", mem_addr, addr);
        chk("rd_rw", mem_rw, 1);
        for (int c = 1; c <= len + 3; c++) begin
            tick();
            if (c <= len) begin
                a = addr + 4'(c);
                chk("rd_addr_seq", mem_addr, a);
            end
            chk("rd_valid", rsp_valid, (c >= 2 && c <= len + 2));
            if (c >= 2 && c <= len + 2) begin
                a = addr + 4'(c - 2);
                chk("rd_data", rsp_data, shadow[a]);
            end
            chk("rd_done", done, (c == len + 2));
            chk("rd_busy", busy, (c < len + 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;

        // Test 1: reset values
        repeat (5) tick();
        chk("rst_ready_low", cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_rw", mem_rw, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);

        // Test 2: write then read same address
        wr(4'd4, 4'd5);
        tick();
        chk("wr_done_pulse", done, 0);
        chk("wr_rw_stays", mem_rw, 1);
        rd(4'd4, 4'd0);

        // Test 3: burst across the 15->0 wrap
        wr(4'd14, 4'd1);
        wr(4'd15, 4'd2);
        wr(4'd0, 4'd3);
        wr(4'd1, 4'd4);
        rd(4'd14, 4'd3);

        // Test 4: command held during a burst is taken on the done edge
        send(2'b10, 4'd14, 4'd0, 4'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 4'd0;
        chk("hold_ready0", cmd_ready, 0);
        tick();
        chk("hold_ready1", cmd_ready, 0);
        tick();
        chk("hold_rsp1", rsp_valid, 1);
        chk("hold_data1", rsp_data, 4'd1);
        chk("hold_ready2", cmd_ready, 0);
        tick();
        chk("hold_rsp2", rsp_valid, 1);
        chk("hold_data2", rsp_data, 4'd2);
        chk("hold_done", done, 1);
        chk("hold_ready3", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("hold_taken_addr", mem_addr, 4'd0);
        chk("hold_taken_busy", busy, 1);
        chk("hold_no_rsp", rsp_valid, 0);
        tick();
        chk("hold_rd_wait", rsp_valid, 0);
        tick();
        chk("hold_rd_valid", rsp_valid, 1);
        chk("hold_rd_data", rsp_data, 4'd3);
        chk("hold_rd_done", done, 1);

        // Reserved op: done at E1, no write cycle
        send(2'b11, 4'd9, 4'd7, 4'd0);
        chk("rsv_rw", mem_rw, 1);
        tick();
        chk("rsv_done", done, 1);
        chk("rsv_rsp", rsp_valid, 0);

        // Test 5: reset during a 16-word burst
        send(2'b10, 4'd0, 4'd0, 4'd15);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_rw", mem_rw, 1);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", rsp_valid | done, 0);
        end
        wr(4'd5, 4'd9);
        rd(4'd5, 4'd0);
        rd(4'd6, 4'd0);

        // Test 6: full 16-word burst
        for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
        rd(4'd0, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
